// File: rtl/io_pkg.sv
// Shared types and constants for the two-port multiplexed I/O sequencer.
// The SCAN_SEL/SCAN_CAP states exist only when IO_SCAN_EN is defined.
package io_pkg;

    localparam int IO_ADDR_W = 4;
    localparam int IO_DATA_W = 8;
    localparam int IO_SEL_W  = 3;
    localparam int IO_CHANS  = 1 << IO_ADDR_W;

    // ioaddr[3] picks the port, ioaddr[2:0] the channel behind its mux
    localparam int   IO_PORT_BIT = IO_ADDR_W - 1;
    localparam logic IO_PORT1    = 1'b0;
    localparam logic IO_PORT2    = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        XFER     = 3'd2,
`ifdef IO_SCAN_EN
        DONE     = 3'd3,
        SCAN_SEL = 3'd4,
        SCAN_CAP = 3'd5
`else
        DONE     = 3'd3
`endif
    } io_state_e;

    function automatic logic io_port_of(input logic [IO_ADDR_W-1:0] addr);
        return addr[IO_PORT_BIT];
    endfunction

    function automatic logic [IO_SEL_W-1:0] io_chan_of(input logic [IO_ADDR_W-1:0] addr);
        return addr[IO_SEL_W-1:0];
    endfunction

endpackage

// File: rtl/io_port_sequencer_if.sv
// CPU-side request/response bus of the I/O port sequencer.
interface io_port_sequencer_if;

    logic                          req;
    logic                          we;
    logic [io_pkg::IO_ADDR_W-1:0]  ioaddr;
    logic [io_pkg::IO_DATA_W-1:0]  wdata;
    logic [io_pkg::IO_DATA_W-1:0]  rdata;
    logic                          ack;
    logic                          busy;

    modport master (
        output req, we, ioaddr, wdata,
        input  rdata, ack, busy
    );

    modport slave (
        input  req, we, ioaddr, wdata,
        output rdata, ack, busy
    );

endinterface

// File: rtl/io_settle_counter.sv
// Loadable down-counter; done flags the final cycle of a loaded interval,
// so a load of N keeps the owning state for exactly N cycles.
module io_settle_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/io_port_sequencer.sv
// Sequences single-byte reads/writes on two multiplexed 8-bit I/O ports.
// Define IO_SCAN_EN to add background input scanning with change interrupt.
module io_port_sequencer
    import io_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    io_port_sequencer_if.slave   cpu,
    output logic [IO_SEL_W-1:0]  p1_sel,
    output logic [IO_SEL_W-1:0]  p2_sel,
    output logic [IO_DATA_W-1:0] p1_out,
    output logic [IO_DATA_W-1:0] p2_out,
    output logic                 p1_oe,
    output logic                 p2_oe,
    input  logic [IO_DATA_W-1:0] p1_in,
    input  logic [IO_DATA_W-1:0] p2_in,
    output logic                 irq,
    output logic [IO_ADDR_W-1:0] irq_ch,
    input  logic                 irq_clr
);

    localparam int                CNT_W     = 8;
    localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]  HOLD_LD   = CNT_W'(HOLD_CYCLES);

    io_state_e              state_q, state_d;
    logic                   we_q;
    logic [IO_ADDR_W-1:0]   addr_q;
    logic [IO_DATA_W-1:0]   wdata_q;
    logic [IO_DATA_W-1:0]   rdata_q;

    logic                   accept;
    logic                   drive_load;
    logic                   cnt_load;
    logic [CNT_W-1:0]       cnt_val;
    logic                   cnt_done;
    logic                   xfer_wr;

`ifdef IO_SCAN_EN
    logic                   scan_start;
    logic                   scan_cap;
    logic [IO_ADDR_W-1:0]   ptr;
    logic [IO_DATA_W-1:0]   shadow [IO_CHANS];
    logic [IO_CHANS-1:0]    valid;
    logic [IO_DATA_W-1:0]   cap_val;
    logic                   irq_q;
    logic [IO_ADDR_W-1:0]   irq_ch_q;
`endif

    io_settle_counter #(.CNT_W(CNT_W)) u_settle (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        drive_load = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = SETTLE_LD;
`ifdef IO_SCAN_EN
        scan_start = 1'b0;
        scan_cap   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (cpu.req) begin
                    accept = 1'b1;
`ifdef IO_SCAN_EN
                end else begin
                    scan_start = 1'b1;
`endif
                end
            end
            SELECT: begin
                if (cnt_done) begin
                    state_d = XFER;
                    if (we_q) begin
                        drive_load = 1'b1;
                        cnt_load   = 1'b1;
                        cnt_val    = HOLD_LD;
                    end
                end
            end
            XFER: begin
                if (!we_q || cnt_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
`ifdef IO_SCAN_EN
            // A CPU request abandons a scan step that has not yet captured
            SCAN_SEL: begin
                if (cpu.req) begin
                    accept = 1'b1;
                end else if (cnt_done) begin
                    state_d = SCAN_CAP;
                end
            end
            SCAN_CAP: begin
                scan_cap = 1'b1;
                state_d  = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d  = SELECT;
            cnt_load = 1'b1;
            cnt_val  = SETTLE_LD;
        end
`ifdef IO_SCAN_EN
        if (scan_start) begin
            state_d  = SCAN_SEL;
            cnt_load = 1'b1;
            cnt_val  = SETTLE_LD;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            p1_sel  <= '0;
            p2_sel  <= '0;
            p1_out  <= '0;
            p2_out  <= '0;
        end else begin
            if (accept) begin
                we_q    <= cpu.we;
                addr_q  <= cpu.ioaddr;
                wdata_q <= cpu.wdata;
                if (io_port_of(cpu.ioaddr) == IO_PORT2) begin
                    p2_sel <= io_chan_of(cpu.ioaddr);
                end else begin
                    p1_sel <= io_chan_of(cpu.ioaddr);
                end
            end
`ifdef IO_SCAN_EN
            if (scan_start) begin
                if (io_port_of(ptr) == IO_PORT2) begin
                    p2_sel <= io_chan_of(ptr);
                end else begin
                    p1_sel <= io_chan_of(ptr);
                end
            end
`endif
            // Pin data changes only as the select settles, never while oe is high on another channel
            if (drive_load) begin
                if (io_port_of(addr_q) == IO_PORT2) begin
                    p2_out <= wdata_q;
                end else begin
                    p1_out <= wdata_q;
                end
            end
            if (state_q == XFER && !we_q) begin
                rdata_q <= (io_port_of(addr_q) == IO_PORT2) ? p2_in : p1_in;
            end
        end
    end

    assign xfer_wr    = (state_q == XFER) && we_q;
    assign p1_oe      = xfer_wr && (io_port_of(addr_q) == IO_PORT1);
    assign p2_oe      = xfer_wr && (io_port_of(addr_q) == IO_PORT2);
    assign cpu.ack    = (state_q == DONE);
    assign cpu.busy   = (state_q == SELECT) || (state_q == XFER) || (state_q == DONE);
    assign cpu.rdata  = rdata_q;

`ifdef IO_SCAN_EN
    assign cap_val = (io_port_of(ptr) == IO_PORT2) ? p2_in : p1_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            valid    <= '0;
            irq_q    <= 1'b0;
            irq_ch_q <= '0;
            for (int i = 0; i < IO_CHANS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            if (scan_cap) begin
                shadow[ptr] <= cap_val;
                valid[ptr]  <= 1'b1;
                ptr         <= ptr + 1'b1;
            end
            // CPU writes define the expected pin value so they never raise a change
            if (state_q == DONE && we_q) begin
                shadow[addr_q] <= wdata_q;
                valid[addr_q]  <= 1'b1;
            end
            if (scan_cap && valid[ptr] && (cap_val != shadow[ptr]) && !irq_q) begin
                irq_q    <= 1'b1;
                irq_ch_q <= ptr;
            end else if (irq_clr) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign irq    = irq_q;
    assign irq_ch = irq_ch_q;
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr;
    assign irq            = 1'b0;
    assign irq_ch         = '0;
`endif

endmodule

// File: tb/tb_io_port_sequencer.sv
// Directed bench for io_port_sequencer; the scan tests build only with IO_SCAN_EN.
module tb_io_port_sequencer;
    import io_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [IO_SEL_W-1:0]  p1_sel, p2_sel;
    logic [IO_DATA_W-1:0] p1_out, p2_out;
    logic                 p1_oe, p2_oe;
    logic [IO_DATA_W-1:0] p1_in, p2_in;
    logic                 irq;
    logic [IO_ADDR_W-1:0] irq_ch;
    logic                 irq_clr;

    // External mux model: each port presents the channel picked by its select
    logic [IO_DATA_W-1:0] p1_mem [8];
    logic [IO_DATA_W-1:0] p2_mem [8];
    assign p1_in = p1_mem[p1_sel];
    assign p2_in = p2_mem[p2_sel];

    int total = 0;
    int bad   = 0;

    io_port_sequencer_if cpu_if ();

    io_port_sequencer #(.SETTLE_CYCLES(2), .HOLD_CYCLES(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .cpu     (cpu_if),
        .p1_sel  (p1_sel),
        .p2_sel  (p2_sel),
        .p1_out  (p1_out),
        .p2_out  (p2_out),
        .p1_oe   (p1_oe),
        .p2_oe   (p2_oe),
        .p1_in   (p1_in),
        .p2_in   (p2_in),
        .irq     (irq),
        .irq_ch  (irq_ch),
        .irq_clr (irq_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise a request and return at cycle 1 (first cycle with busy high)
    task automatic start_req(input logic w, input logic [3:0] a, input logic [7:0] d, input string tag);
        logic got;
        got = 1'b0;
        cpu_if.req    = 1'b1;
        cpu_if.we     = w;
        cpu_if.ioaddr = a;
        cpu_if.wdata  = d;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = cpu_if.busy;
        end
        chk({tag, "_accept"}, 32'(got), 32'd1);
    endtask

    initial begin
        int  n;
        logic seen;
        reset         = 1'b1;
        irq_clr       = 1'b0;
        cpu_if.req    = 1'b0;
        cpu_if.we     = 1'b0;
        cpu_if.ioaddr = '0;
        cpu_if.wdata  = '0;
        for (int i = 0; i < 8; i++) begin
            p1_mem[i] = 8'h10 + 8'(i);
            p2_mem[i] = 8'h20 + 8'(i);
        end
        tick(); tick(); tick();

        chk("rst_ack",    32'(cpu_if.ack),   0);
        chk("rst_busy",   32'(cpu_if.busy),  0);
        chk("rst_rdata",  32'(cpu_if.rdata), 0);
        chk("rst_oe",     32'({p1_oe, p2_oe}), 0);
        chk("rst_sel",    32'({p1_sel, p2_sel}), 0);
        chk("rst_out",    32'({p1_out, p2_out}), 0);
        chk("rst_irq",    32'({irq, irq_ch}), 0);
        reset = 1'b0;
        tick();

        // Write 0xA5 to address 0x3
        start_req(1'b1, 4'h3, 8'hA5, "wr");
        chk("wr_c1_sel",  32'(p1_sel), 3);
        chk("wr_c1_oe",   32'(p1_oe), 0);
        tick();
        chk("wr_c2_oe",   32'(p1_oe), 0);
        tick();
        chk("wr_c3_oe",   32'(p1_oe), 1);
        chk("wr_c3_out",  32'(p1_out), 32'hA5);
        chk("wr_c3_p2oe", 32'(p2_oe), 0);
        chk("wr_c3_ack",  32'(cpu_if.ack), 0);
        tick();
        chk("wr_c4_ack",  32'(cpu_if.ack), 1);
        chk("wr_c4_oe",   32'(p1_oe), 0);
        chk("wr_c4_busy", 32'(cpu_if.busy), 1);
        cpu_if.req = 1'b0;
        tick();
        chk("wr_c5_ack",  32'(cpu_if.ack), 0);
        chk("wr_c5_busy", 32'(cpu_if.busy), 0);
        chk("wr_p2_out",  32'(p2_out), 0);
        chk("wr_p1_hold", 32'(p1_out), 32'hA5);
`ifndef IO_SCAN_EN
        chk("wr_p2_sel",  32'(p2_sel), 0);
`endif

        // Read address 0xE with channel 6 of port 2 at 0x5C
        p2_mem[6] = 8'h5C;
        start_req(1'b0, 4'hE, 8'h00, "rd");
        chk("rd_c1_sel",  32'(p2_sel), 6);
        chk("rd_c1_oe",   32'(p2_oe), 0);
        tick();
        chk("rd_c2_oe",   32'(p2_oe), 0);
        tick();
        chk("rd_c3_oe",   32'(p2_oe), 0);
        chk("rd_c3_ack",  32'(cpu_if.ack), 0);
        tick();
        chk("rd_c4_ack",  32'(cpu_if.ack), 1);
        chk("rd_c4_data", 32'(cpu_if.rdata), 32'h5C);
        cpu_if.req = 1'b0;
        p2_mem[6]  = 8'h00;
        tick();
        chk("rd_hold",    32'(cpu_if.rdata), 32'h5C);
        chk("rd_c5_ack",  32'(cpu_if.ack), 0);
`ifndef IO_SCAN_EN
        chk("rd_p1_sel",  32'(p1_sel), 3);
`endif

        // Back-to-back: write 0x1 then read 0x9 with req held throughout
        p2_mem[1] = 8'h77;
        start_req(1'b1, 4'h1, 8'h33, "b2b");
        chk("b2b_sel1",   32'(p1_sel), 1);
        tick(); tick(); tick();
        chk("b2b_ack1",   32'(cpu_if.ack), 1);
        cpu_if.we     = 1'b0;
        cpu_if.ioaddr = 4'h9;
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            n++;
            if (n == 1) chk("b2b_gap_busy", 32'(cpu_if.busy), 0);
            if (n == 2) chk("b2b_p2_sel", 32'(p2_sel), 1);
            seen = cpu_if.ack;
        end
        chk("b2b_spacing", 32'(n), 5);
        chk("b2b_rdata",   32'(cpu_if.rdata), 32'h77);
        chk("b2b_p1_sel",  32'(p1_sel), 1);
        chk("b2b_p1_out",  32'(p1_out), 32'h33);
        cpu_if.req = 1'b0;
        tick();

        // Port 2 channel 7 write leaves port 1 alone
        start_req(1'b1, 4'hF, 8'h3C, "wr2");
        chk("wr2_sel",    32'(p2_sel), 7);
        tick();
        chk("wr2_c2_oe",  32'(p2_oe), 0);
        tick();
        chk("wr2_c3_oe",  32'({p1_oe, p2_oe}), 1);
        chk("wr2_out",    32'(p2_out), 32'h3C);
        chk("wr2_p1_out", 32'(p1_out), 32'h33);
        tick();
        chk("wr2_ack",    32'(cpu_if.ack), 1);
        cpu_if.req = 1'b0;
        tick();

        // Reset asserted in cycle 3 of a write
        start_req(1'b1, 4'h3, 8'h5A, "rstw");
        tick(); tick();
        chk("rstw_c3_oe", 32'(p1_oe), 1);
        reset      = 1'b1;
        cpu_if.req = 1'b0;
        tick();
        chk("rstw_oe",    32'(p1_oe), 0);
        chk("rstw_busy",  32'(cpu_if.busy), 0);
        chk("rstw_ack",   32'(cpu_if.ack), 0);
        chk("rstw_out",   32'(p1_out), 0);
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | cpu_if.ack;
        end
        chk("rstw_no_ack", 32'(seen), 0);

`ifdef IO_SCAN_EN
        // One full sweep validates every shadow
        for (int i = 0; i < 70; i++) tick();
        chk("scan_quiet", 32'(irq), 0);
        p1_mem[2] = 8'hEE;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            tick();
            seen = irq;
        end
        chk("scan_irq",    32'(irq), 1);
        chk("scan_irq_ch", 32'(irq_ch), 2);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        chk("scan_clr",    32'(irq), 0);

        // Clear held across the capture edge: set wins
        irq_clr   = 1'b1;
        p1_mem[5] = 8'hBB;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            tick();
            seen = irq;
        end
        irq_clr = 1'b0;
        chk("scan_coinc",    32'(irq), 1);
        chk("scan_coinc_ch", 32'(irq_ch), 5);

        // Now IDLE with ptr at 6; next edge opens the channel 6 step
        tick();
        chk("scan_sel6", 32'(p1_sel), 6);
        cpu_if.req    = 1'b1;
        cpu_if.we     = 1'b0;
        cpu_if.ioaddr = 4'h9;
        tick();
        chk("abort_busy", 32'(cpu_if.busy), 1);
        chk("abort_sel",  32'(p2_sel), 1);
        tick(); tick(); tick();
        chk("abort_ack",   32'(cpu_if.ack), 1);
        chk("abort_rdata", 32'(cpu_if.rdata), 32'h77);
        cpu_if.req = 1'b0;
        tick(); tick();
        chk("abort_ptr",  32'(p1_sel), 6);
`else
        irq_clr = 1'b1;
        tick();
        chk("noscan_irq", 32'({irq, irq_ch}), 0);
        irq_clr = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        chk("noscan_idle", 32'({irq, irq_ch, cpu_if.busy}), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
